requant_pipe: RTL and testbench
===============================

Name: requant_pipe

Overview:
- Parametrised, pipelined successor to the single-lane accumulator-to-int8 compressor.
- Takes LANES signed accumulator sums per beat. Each lane gets an arithmetic right shift by a runtime amount, then is saturated to a signed OUT_WIDTH result.
- Uses a valid/ready handshake and keeps a running count of saturated lanes.
- Sits between the MAC accumulator array and the activation/writeback buffer.

Parameters:
- SUM_WIDTH, 20, signed accumulator width per lane.
- OUT_WIDTH, 8, signed output width per lane (2..SUM_WIDTH-1).
- LANES, 4, number of parallel channels per beat.
- SHIFT_WIDTH, 5, width of the runtime shift field.
- CNT_WIDTH, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_sum  in  LANES*SUM_WIDTH  lane i at bits [i*SUM_WIDTH +: SUM_WIDTH], signed.
- in_shift  in  SHIFT_WIDTH  right-shift amount, sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  LANES*OUT_WIDTH  lane i at bits [i*OUT_WIDTH +: OUT_WIDTH], signed.
- out_sat  out  LANES  per-lane flag: lane result was clamped.
- sat_count  out  CNT_WIDTH  count of saturated lanes since reset/clear.
- sat_clr  in  1  synchronous clear of sat_count.

Behaviour:
- Reset (rst=1 at an edge):
  - stage valids v1 and v2 = 0, so out_valid = 0.
  - out_data, out_sat, sat_count = 0.
  - in_ready = 1 in the first cycle after reset.
  - Any in-flight beats are discarded.
- Pipeline control:
  - adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1 (combinational).
  - Throughput is one beat per cycle at full rate.
- Stage 1 (loads when adv1):
  - v1 <= in_valid.
  - Per lane: s1 = in_sum >>> sh, where sh = min(in_shift, SUM_WIDTH-1). The shift is arithmetic (sign-extending).
  - s1 is held at SUM_WIDTH+1 bits.
- Stage 2 (loads when adv2):
  - v2 <= v1.
  - Per lane: if s1 > 2^(OUT_WIDTH-1)-1, out = max positive and out_sat = 1.
  - Else if s1 < -2^(OUT_WIDTH-1), out = min negative and out_sat = 1.
  - Otherwise out = s1[OUT_WIDTH-1:0] and out_sat = 0.
- Latency: 2 cycles from accepted input to out_valid, given no backpressure.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_sat hold stable and out_valid stays 1.
- Bubbles: when v1=0, stage 2 still loads v2=0 if adv2. Data registers may update but carry no meaning.
- sat_count:
  - Updated when stage 2 loads a valid beat (adv2 & v1). Adds popcount of the new sat flags.
  - Saturates at 2^CNT_WIDTH-1 with no wrap.
  - sat_clr=1 forces 0; clear wins over a same-cycle increment.
- in_shift = 0: result is the input saturated, no scaling.
- in_shift >= SUM_WIDTH-1: each lane becomes 0 or -1 by sign.
- With in_shift = 8, SUM_WIDTH = 20, OUT_WIDTH = 8 (macro off): bit-exact to the legacy compressor (bits [15:8] with clamp).

Optional Feature:
- Macro: REQUANT_ROUND_EN.
- Defined: round-half-up. Stage 1 computes (in_sum + (sh>0 ? 1<<(sh-1) : 0)) >>> sh in SUM_WIDTH+1 bits, so the add never overflows. Saturation in stage 2 applies to the rounded value.
- Undefined: truncation (floor) as above, and the rounding adder is absent.

Test Plan:
- Reset, then shift=8; lanes = 0x00A40, 0x7FFFF, 0x80000, 0xFFF00 (20-bit), out_ready=1 -> after 2 cycles:
  - out_data lanes = 0x0A, 0x7F, 0x80, 0xFF.
  - out_sat = 4'b0110; sat_count = 2.
- Stream 10 random beats back-to-back with out_ready=1 -> in_ready stays 1, 10 outputs in order, and each matches the golden model.
- Hold out_ready=0 for 5 cycles mid-stream -> out_data stable; in_ready drops after 2 beats are buffered; no beat lost or duplicated after release.
- Shift=0, lane = 200 -> 127 with sat flagged. Shift=25, lane = -5 -> -1. Shift=25, lane = 5 -> 0.
- Preload sat_count = 0xFFFE, then a beat with 4 saturating lanes -> 0xFFFF. sat_clr asserted in the same cycle as a saturating beat -> 0.
- REQUANT_ROUND_EN defined, shift=8: lane 0x00180 -> 2, lane 0x0017F -> 1, lane 0x7FF80 -> 127 with sat flagged. Macro off: 0x00180 -> 1.

Source files
------------

// File: rtl/requant_pipe.sv
// requant_pipe: per-lane arithmetic right shift then signed saturation, two-stage valid/ready pipeline.
// Define REQUANT_ROUND_EN for round-half-up before the shift; default build truncates (floor).

module requant_pipe #(
  parameter int unsigned SUM_WIDTH   = 20,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned LANES       = 4,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*SUM_WIDTH-1:0]   in_sum,
  input  logic [SHIFT_WIDTH-1:0]       in_shift,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*OUT_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]             out_sat,
  output logic [CNT_WIDTH-1:0]         sat_count,
  input  logic                         sat_clr
);

  localparam int unsigned EXT_W   = SUM_WIDTH + 1;
  localparam int unsigned SH_MAX  = SUM_WIDTH - 1;
  localparam int unsigned POP_W   = $clog2(LANES + 1);
  localparam int unsigned CNT_EXT = CNT_WIDTH + 1;
  localparam int          OUT_MAX = int'((2 ** (OUT_WIDTH - 1)) - 1);

  localparam logic signed [EXT_W-1:0]  POS_LIM = EXT_W'(OUT_MAX);
  localparam logic signed [EXT_W-1:0]  NEG_LIM = EXT_W'(-OUT_MAX - 1);
  localparam logic [OUT_WIDTH-1:0]     OUT_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0]     OUT_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic                    v1;
  logic                    v2;
  logic                    adv1;
  logic                    adv2;
  logic [SHIFT_WIDTH-1:0]  sh_c;
  logic signed [EXT_W-1:0] s1_d [LANES];
  logic signed [EXT_W-1:0] s1_q [LANES];
  logic [LANES*OUT_WIDTH-1:0] data_c;
  logic [LANES-1:0]        sat_c;
  logic [POP_W-1:0]        pop_c;
  logic [CNT_EXT-1:0]      cnt_sum;

  // Each stage advances when its slot is empty or the slot ahead is moving.
  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  // Shifting beyond SUM_WIDTH-1 adds nothing but sign bits, so clamp there.
  always_comb begin
    sh_c = in_shift;
    if (32'(in_shift) > SH_MAX) begin
      sh_c = SHIFT_WIDTH'(SH_MAX);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] biased;
    logic                    sat_hi;
    logic                    sat_lo;

    assign ext = {in_sum[g*SUM_WIDTH + SUM_WIDTH - 1], in_sum[g*SUM_WIDTH +: SUM_WIDTH]};
`ifdef REQUANT_ROUND_EN
    // One extra bit of headroom keeps the half-LSB bias from overflowing.
    assign biased = (sh_c == '0) ? ext : ext + (EXT_W'(1) << (sh_c - SHIFT_WIDTH'(1)));
`else
    assign biased = ext;
`endif
    assign s1_d[g] = biased >>> sh_c;

    assign sat_hi = s1_q[g] > POS_LIM;
    assign sat_lo = s1_q[g] < NEG_LIM;
    assign sat_c[g] = sat_hi || sat_lo;
    assign data_c[g*OUT_WIDTH +: OUT_WIDTH] =
      sat_hi ? OUT_POS : (sat_lo ? OUT_NEG : s1_q[g][OUT_WIDTH-1:0]);
  end

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_c = pop_c + POP_W'(sat_c[i]);
    end
  end

  assign cnt_sum = {1'b0, sat_count} + CNT_EXT'(pop_c);

  // Stage 1: scaled lane values.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_q[i] <= '0;
      end
    end else if (adv1) begin
      v1 <= in_valid;
      for (int i = 0; i < LANES; i++) begin
        s1_q[i] <= s1_d[i];
      end
    end
  end

  // Stage 2: saturated outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2       <= 1'b0;
      out_data <= '0;
      out_sat  <= '0;
    end else if (adv2) begin
      v2       <= v1;
      out_data <= data_c;
      out_sat  <= sat_c;
    end
  end

  // Saturation event counter; clear has priority, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (adv2 && v1) begin
      if (cnt_sum[CNT_WIDTH]) begin
        sat_count <= '1;
      end else begin
        sat_count <= cnt_sum[CNT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_requant_pipe.sv
// Directed and model-checked bench for requant_pipe at default parameters.
module tb_requant_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] in_sum;
  logic [4:0]  in_shift;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_sat;
  logic [15:0] sat_count;
  logic        sat_clr;

  int n_tests = 0;
  int n_fail  = 0;

  requant_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_shift(in_shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_count(sat_count), .sat_clr(sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [79:0] pack(input logic [19:0] l0, input logic [19:0] l1,
                                       input logic [19:0] l2, input logic [19:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference: integer shift and clamp per lane.
  function automatic void model(input logic [79:0] sum, input logic [4:0] shift,
                                output logic [31:0] d, output logic [3:0] s);
    longint v;
    int sh;
    sh = (int'(shift) > 19) ? 19 : int'(shift);
    for (int i = 0; i < 4; i++) begin
      v = longint'($signed(sum[i*20 +: 20]));
`ifdef REQUANT_ROUND_EN
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
      v = v >>> sh;
      if (v > 127) begin
        d[i*8 +: 8] = 8'h7F; s[i] = 1'b1;
      end else if (v < -128) begin
        d[i*8 +: 8] = 8'h80; s[i] = 1'b1;
      end else begin
        d[i*8 +: 8] = 8'(v); s[i] = 1'b0;
      end
    end
  endfunction

  // Drives one beat into an idle pipe and returns what emerges (lat = -1 on timeout).
  task automatic send_single(input logic [79:0] sum, input logic [4:0] sh,
                             output logic [31:0] d, output logic [3:0] s,
                             output logic [15:0] c, output int lat);
    d = 'x; s = 'x; c = 'x; lat = -1;
    @(negedge clk);
    in_valid = 1'b1; in_sum = sum; in_shift = sh; out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) begin
        lat = k; d = out_data; s = out_sat; c = sat_count;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_tests++; if (out_sat !== 4'h0) begin n_fail++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
    n_tests++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL reset_sat_count: got %h want 0", sat_count); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [3:0] s; logic [15:0] c; int lat;
    send_single(pack(20'h00A40, 20'h7FFFF, 20'h80000, 20'hFFF00), 5'd8, d, s, c, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", lat); end
    n_tests++; if (d !== 32'hFF807F0A) begin n_fail++; $display("FAIL basic_data: got %h want ff807f0a", d); end
    n_tests++; if (s !== 4'b0110) begin n_fail++; $display("FAIL basic_sat: got %b want 0110", s); end
    n_tests++; if (c !== 16'd2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", c); end
  endtask

  task automatic test_shift_edges();
    logic [31:0] d; logic [3:0] s; logic [15:0] c; int lat;
    logic [31:0] exp_b;
    logic [31:0] exp_r;
`ifdef REQUANT_ROUND_EN
    exp_b = 32'hFF010000;
    exp_r = 32'h017F0102;
`else
    exp_b = 32'hFF0000FF;
    exp_r = 32'h007F0101;
`endif
    send_single(pack(20'd200, 20'(-200), 20'd127, 20'(-128)), 5'd0, d, s, c, lat);
    n_tests++; if (d !== 32'h807F807F) begin n_fail++; $display("FAIL shift0_data: got %h want 807f807f", d); end
    n_tests++; if (s !== 4'b0011) begin n_fail++; $display("FAIL shift0_sat: got %b want 0011", s); end
    n_tests++; if (c !== 16'd4) begin n_fail++; $display("FAIL shift0_count: got %0d want 4", c); end
    send_single(pack(20'(-5), 20'd5, 20'h7FFFF, 20'h80000), 5'd25, d, s, c, lat);
    n_tests++; if (d !== exp_b) begin n_fail++; $display("FAIL shift25_data: got %h want %h", d, exp_b); end
    n_tests++; if (s !== 4'b0000) begin n_fail++; $display("FAIL shift25_sat: got %b want 0000", s); end
    send_single(pack(20'(-5), 20'd5, 20'h7FFFF, 20'h80000), 5'd31, d, s, c, lat);
    n_tests++; if (d !== exp_b) begin n_fail++; $display("FAIL shift31_data: got %h want %h", d, exp_b); end
    send_single(pack(20'h00180, 20'h0017F, 20'h7FF80, 20'h00080), 5'd8, d, s, c, lat);
    n_tests++; if (d !== exp_r) begin n_fail++; $display("FAIL round_data: got %h want %h", d, exp_r); end
    n_tests++; if (s !== 4'b0100) begin n_fail++; $display("FAIL round_sat: got %b want 0100", s); end
    n_tests++; if (c !== 16'd5) begin n_fail++; $display("FAIL round_count: got %0d want 5", c); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] qd[$]; logic [3:0] qs[$];
    logic [31:0] md; logic [3:0] ms;
    int sent = 0; int got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      @(negedge clk);
      if (sent < 10) begin
        in_valid = 1'b1;
        in_sum   = {16'($urandom), 32'($urandom), 32'($urandom)};
        in_shift = 5'($urandom_range(0, 31));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        n_tests++;
        if (qd.size() == 0) begin
          n_fail++; $display("FAIL b2b_spurious: got beat %h want none", out_data);
        end else if (out_data !== qd[0] || out_sat !== qs[0]) begin
          n_fail++; $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", got, out_data, out_sat, qd[0], qs[0]);
        end
        if (qd.size() != 0) begin void'(qd.pop_front()); void'(qs.pop_front()); end
        got++;
      end
      if (sent < 10) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
      end
      if (in_valid && in_ready) begin
        model(in_sum, in_shift, md, ms);
        qd.push_back(md); qs.push_back(ms);
        sent++;
      end
    end
    in_valid = 1'b0;
    n_tests++; if (got !== 10) begin n_fail++; $display("FAIL b2b_count: got %0d want 10", got); end
  endtask

  task automatic test_backpressure();
    logic [31:0] qd[$]; logic [3:0] qs[$];
    logic [31:0] md; logic [3:0] ms;
    logic [31:0] prev_d;
    logic        stalled = 1'b0;
    logic        exp_rdy;
    logic        saw_low = 1'b0;
    logic        pending = 1'b0;
    int sent = 0; int got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 8);
      if (!pending && sent < 8) begin
        in_sum   = {16'($urandom), 32'($urandom), 32'($urandom)};
        in_shift = 5'($urandom_range(0, 12));
        pending  = 1'b1;
      end
      in_valid = pending;
      #1;
      exp_rdy = !(qd.size() >= 2 && !out_ready);
      n_tests++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, in_ready, exp_rdy); end
      if (!in_ready) saw_low = 1'b1;
      if (stalled) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== prev_d) begin
          n_fail++; $display("FAIL bp_hold cyc%0d: got %b/%h want 1/%h", cyc, out_valid, out_data, prev_d);
        end
      end
      stalled = out_valid && !out_ready;
      prev_d  = out_data;
      if (out_valid && out_ready) begin
        n_tests++;
        if (qd.size() == 0) begin
          n_fail++; $display("FAIL bp_spurious: got beat %h want none", out_data);
        end else if (out_data !== qd[0] || out_sat !== qs[0]) begin
          n_fail++; $display("FAIL bp_beat%0d: got %h/%b want %h/%b", got, out_data, out_sat, qd[0], qs[0]);
        end
        if (qd.size() != 0) begin void'(qd.pop_front()); void'(qs.pop_front()); end
        got++;
      end
      if (in_valid && in_ready) begin
        model(in_sum, in_shift, md, ms);
        qd.push_back(md); qs.push_back(ms);
        sent++;
        pending = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++; if (got !== 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", got); end
    n_tests++; if (saw_low !== 1'b1) begin n_fail++; $display("FAIL bp_stall_seen: got %b want 1", saw_low); end
  endtask

  task automatic test_sat_counter();
    logic [31:0] d; logic [3:0] s; logic [15:0] c; int lat;
    @(negedge clk); sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
    #1;
    n_tests++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL clr_only: got %h want 0", sat_count); end
    out_ready = 1'b1;
    for (int k = 0; k < 16383; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_shift = 5'd0;
      in_sum = pack(20'h7FFFF, 20'h80000, 20'h7FFFF, 20'h80000);
    end
    @(negedge clk);
    in_sum = pack(20'h7FFFF, 20'h80000, 20'h0, 20'h0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (sat_count !== 16'hFFFE) begin n_fail++; $display("FAIL cnt_fill: got %h want fffe", sat_count); end
    send_single(pack(20'h7FFFF, 20'h80000, 20'h7FFFF, 20'h80000), 5'd0, d, s, c, lat);
    n_tests++; if (c !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_top: got %h want ffff", c); end
    n_tests++; if (s !== 4'hF) begin n_fail++; $display("FAIL cnt_top_sat: got %b want 1111", s); end
    n_tests++; if (d !== 32'h807F807F) begin n_fail++; $display("FAIL cnt_top_data: got %h want 807f807f", d); end
    send_single(pack(20'h7FFFF, 20'h80000, 20'h7FFFF, 20'h80000), 5'd0, d, s, c, lat);
    n_tests++; if (c !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_nowrap: got %h want ffff", c); end
    @(negedge clk);
    in_valid = 1'b1; in_sum = pack(20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF); in_shift = 5'd0;
    @(negedge clk);
    in_valid = 1'b0; sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_race_valid: got %b want 1", out_valid); end
    n_tests++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL clr_race_count: got %h want 0", sat_count); end
    @(negedge clk);
    #1;
    n_tests++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL clr_race_after: got %h want 0", sat_count); end
  endtask

  task automatic test_reset_flush();
    logic seen = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_shift = 5'd0; in_sum = pack(20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF);
    @(negedge clk);
    in_sum = pack(20'h80000, 20'h80000, 20'h80000, 20'h80000);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++; if (sat_count !== 16'd4) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 4", sat_count); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_tests++; if (out_data !== 32'h0 || out_sat !== 4'h0) begin n_fail++; $display("FAIL flush_data: got %h/%b want 0/0", out_data, out_sat); end
    n_tests++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL flush_count: got %h want 0", sat_count); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    repeat (3) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_leak: got %b want 0", seen); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_shift = '0;
    out_ready = 1'b1; sat_clr = 1'b0;
    test_reset();
    test_basic();
    test_shift_edges();
    test_back_to_back();
    test_backpressure();
    test_sat_counter();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
